mem_response_merger: RTL and testbench
======================================

# mem_response_merger

Write-response merger on the AXI write path, downstream of the 4 KB request splitter. Tracks every original write request in issue order, along with whether the splitter broke it into two sub-bursts. Consumes AXI B responses and returns exactly one completion per original request; a split request completes only after both of its B responses arrive, carrying the merged response code.

## Interface
Parameters:
- TRACK_DEPTH, 8, outstanding original requests tracked; power of 2, ≥2.
- RESP_WIDTH, 2, AXI BRESP width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- req_push  in  1  one original request issued; sample together with req_is_split.
- req_is_split  in  1  request was issued as two sub-bursts (A then B).
- req_ready  out  1  tracker not full.
- axi_bvalid  in  1  AXI write response valid.
- axi_bresp  in  RESP_WIDTH  AXI write response code.
- axi_bready  out  1  AXI write response ready.
- cmpl_valid  out  1  merged completion valid.
- cmpl_resp  out  RESP_WIDTH  merged response code.
- cmpl_split  out  1  completion belongs to a split request.
- cmpl_ready  in  1  completion consumer ready.
- outstanding_count  out  $clog2(TRACK_DEPTH)+1  tracked requests not yet completed.
- push_overflow_err  out  1  sticky; set when req_push arrives while full.

## Operation
- Tracker FIFO is TRACK_DEPTH deep with 1-bit entries (is_split).
- Push on req_push && req_ready.
- Push while full: entry is dropped, push_overflow_err is set, and it stays set until reset.
- Pop occurs only on the completion handshake (cmpl_valid && cmpl_ready).
- Pointers wrap modulo TRACK_DEPTH. Full and empty are derived from the registered count.
- Push and pop in the same cycle: count is unchanged and both operations occur. Push into a full FIFO is still rejected, even when a pop happens in the same cycle.
- FSM states:
  - IDLE: axi_bready = !empty. On B handshake: if head is_split, acc <= bresp and go to WAIT_SECOND; else cmpl_resp <= bresp, cmpl_split <= 0, go to CMPL.
  - WAIT_SECOND: axi_bready = 1. On B handshake: cmpl_resp <= merge(acc, bresp), cmpl_split <= 1, go to CMPL.
  - CMPL: cmpl_valid = 1, axi_bready = 0. On cmpl_ready: pop head, go to IDLE.
- merge(a, b):
  - If a ≥ 2 or b ≥ 2 (SLVERR/DECERR), result is max(a, b).
  - Otherwise result is a & b, so EXOKAY only when both halves are EXOKAY.
- B response with an empty tracker in IDLE: not accepted (axi_bready = 0), no state change.
- Empty is a registered signal; there is no bypass. A push makes axi_bready visible the following cycle.

## Timing
- Reset values:
  - state IDLE, count 0, pointers 0.
  - cmpl_valid 0, cmpl_resp 0, cmpl_split 0.
  - axi_bready 0, req_ready 1, push_overflow_err 0.
- Reset asserted mid-operation discards all tracked entries and any partial accumulation.
- Completion latency: cmpl_valid rises the cycle after the final B handshake.
- cmpl_resp and cmpl_split are stable while cmpl_valid && !cmpl_ready.
- Throughput:
  - One completion per 2 cycles for unsplit requests.
  - Split requests: 3 cycles minimum from first B handshake to completion handshake.
- req_ready = (count != TRACK_DEPTH), registered-count based. After a pop, it rises the next cycle.
- Order: completions are returned strictly in push order.

## Test plan
- Push 1 unsplit; B bresp=0 one cycle later; cmpl_ready=1 -> cmpl_valid one cycle after the B handshake with resp=0, split=0; count returns to 0.
- Push 1 split; B responses 0 then 2 -> exactly one completion with resp=2, split=1, and only after the second B; axi_bready=0 during CMPL.
- Split with B = 1,1 -> resp=1; B = 1,0 -> resp=0; B = 3,2 -> resp=3.
- Push 9 with TRACK_DEPTH=8 and no responses -> req_ready=0 after 8 pushes; 9th dropped; push_overflow_err=1; count=8. Drain 8 mixed split/unsplit in order; count reaches 0; error flag stays 1.
- axi_bvalid=1 with an empty tracker -> axi_bready=0 and no completion. Push in cycle N -> axi_bready=1 in N+1.
- Reset (low) asserted in WAIT_SECOND with 3 outstanding -> outputs go immediately to reset values; after release count=0 and no completion emitted.

Source files
------------

// File: rtl/mem_response_merger.sv
// mem_response_merger
// Merges AXI write responses back into one completion per original write
// request. The upstream 4 KB splitter may have broken a request into two
// sub-bursts; each request is recorded in issue order together with its
// split flag. A split request completes only after both of its B responses
// arrive, and its completion carries the merged response code.
//
// Ports:
//   clk               clock
//   reset             asynchronous, active-low reset
//   req_push          an original request was issued (with req_is_split)
//   req_is_split      the request went out as two sub-bursts
//   req_ready         tracker is not full
//   axi_bvalid        AXI B channel valid
//   axi_bresp         AXI B channel response code
//   axi_bready        AXI B channel ready
//   cmpl_valid        merged completion valid
//   cmpl_resp         merged completion response code
//   cmpl_split        completion belongs to a split request
//   cmpl_ready        completion consumer ready
//   outstanding_count tracked requests not yet completed
//   push_overflow_err sticky flag: a push arrived while the tracker was full
module mem_response_merger #(
  parameter int TRACK_DEPTH = 8,
  parameter int RESP_WIDTH  = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         req_push,
  input  logic                         req_is_split,
  output logic                         req_ready,
  input  logic                         axi_bvalid,
  input  logic [RESP_WIDTH-1:0]        axi_bresp,
  output logic                         axi_bready,
  output logic                         cmpl_valid,
  output logic [RESP_WIDTH-1:0]        cmpl_resp,
  output logic                         cmpl_split,
  input  logic                         cmpl_ready,
  output logic [$clog2(TRACK_DEPTH):0] outstanding_count,
  output logic                         push_overflow_err
);

  localparam int PTR_W = $clog2(TRACK_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] ST_IDLE        = 2'd0;
  localparam logic [1:0] ST_WAIT_SECOND = 2'd1;
  localparam logic [1:0] ST_CMPL        = 2'd2;

  // Tracker storage: one split flag per outstanding request.
  logic [TRACK_DEPTH-1:0] entry_reg;

  logic [PTR_W-1:0]      wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]      rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0]      count_reg, count_next;
  logic                  overflow_reg, overflow_next;
  logic [1:0]            state_reg, state_next;
  logic [RESP_WIDTH-1:0] acc_reg, acc_next;
  logic [RESP_WIDTH-1:0] resp_reg, resp_next;
  logic                  split_reg, split_next;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic b_hs;
  logic head_split;

  // SLVERR/DECERR dominate (worst error wins); otherwise the result is
  // EXOKAY only when both halves were EXOKAY.
  function automatic logic [RESP_WIDTH-1:0] merge_resp(
    input logic [RESP_WIDTH-1:0] a,
    input logic [RESP_WIDTH-1:0] b
  );
    logic [RESP_WIDTH-1:0] result;
    if (int'(a) >= 2 || int'(b) >= 2) begin
      result = (a > b) ? a : b;
    end else begin
      result = a & b;
    end
    return result;
  endfunction

  // Full/empty come from the registered count only; there is no bypass, so
  // a push becomes visible on axi_bready one cycle later.
  assign full       = (count_reg == CNT_W'(TRACK_DEPTH));
  assign empty      = (count_reg == '0);
  assign req_ready  = !full;
  assign push       = req_push && !full;
  assign cmpl_valid = (state_reg == ST_CMPL);
  assign pop        = cmpl_valid && cmpl_ready;
  assign axi_bready = ((state_reg == ST_IDLE) && !empty) ||
                      (state_reg == ST_WAIT_SECOND);
  assign b_hs       = axi_bvalid && axi_bready;
  assign head_split = entry_reg[rd_ptr_reg];

  assign cmpl_resp         = resp_reg;
  assign cmpl_split        = split_reg;
  assign outstanding_count = count_reg;
  assign push_overflow_err = overflow_reg;

  always_comb begin
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    count_next    = count_reg;
    overflow_next = overflow_reg;

    if (push) begin
      wr_ptr_next = wr_ptr_reg + 1'b1;
    end
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + 1'b1;
    end
    if (push && !pop) begin
      count_next = count_reg + 1'b1;
    end else if (pop && !push) begin
      count_next = count_reg - 1'b1;
    end
    // A push against a full tracker is rejected even if a pop happens in
    // the same cycle, because full is taken from the registered count.
    if (req_push && full) begin
      overflow_next = 1'b1;
    end
  end

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    resp_next  = resp_reg;
    split_next = split_reg;

    case (state_reg)
      ST_IDLE: begin
        if (b_hs) begin
          if (head_split) begin
            acc_next   = axi_bresp;
            state_next = ST_WAIT_SECOND;
          end else begin
            resp_next  = axi_bresp;
            split_next = 1'b0;
            state_next = ST_CMPL;
          end
        end
      end
      ST_WAIT_SECOND: begin
        if (b_hs) begin
          resp_next  = merge_resp(acc_reg, axi_bresp);
          split_next = 1'b1;
          state_next = ST_CMPL;
        end
      end
      ST_CMPL: begin
        if (cmpl_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
      state_reg    <= ST_IDLE;
      acc_reg      <= '0;
      resp_reg     <= '0;
      split_reg    <= 1'b0;
    end else begin
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      count_reg    <= count_next;
      overflow_reg <= overflow_next;
      state_reg    <= state_next;
      acc_reg      <= acc_next;
      resp_reg     <= resp_next;
      split_reg    <= split_next;
    end
  end

  // Entries are only read while counted as valid, so they need no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      entry_reg[wr_ptr_reg] <= req_is_split;
    end
  end

endmodule

// File: tb/tb_mem_response_merger.sv
// Testbench for mem_response_merger: directed scenarios plus a randomized
// run checked against a queue-based reference model.
module tb_mem_response_merger;

  localparam int D  = 8;
  localparam int RW = 2;

  localparam logic [1:0] OKAY   = 2'd0;
  localparam logic [1:0] EXOKAY = 2'd1;
  localparam logic [1:0] SLVERR = 2'd2;
  localparam logic [1:0] DECERR = 2'd3;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_push;
  logic          req_is_split;
  logic          req_ready;
  logic          axi_bvalid;
  logic [RW-1:0] axi_bresp;
  logic          axi_bready;
  logic          cmpl_valid;
  logic [RW-1:0] cmpl_resp;
  logic          cmpl_split;
  logic          cmpl_ready;
  logic [3:0]    outstanding_count;
  logic          push_overflow_err;

  int total = 0;
  int bad   = 0;

  mem_response_merger #(.TRACK_DEPTH(D), .RESP_WIDTH(RW)) dut (
    .clk               (clk),
    .reset             (reset),
    .req_push          (req_push),
    .req_is_split      (req_is_split),
    .req_ready         (req_ready),
    .axi_bvalid        (axi_bvalid),
    .axi_bresp         (axi_bresp),
    .axi_bready        (axi_bready),
    .cmpl_valid        (cmpl_valid),
    .cmpl_resp         (cmpl_resp),
    .cmpl_split        (cmpl_split),
    .cmpl_ready        (cmpl_ready),
    .outstanding_count (outstanding_count),
    .push_overflow_err (push_overflow_err)
  );

  always #5 clk = ~clk;

  // Reference merge rule, phrased in terms of AXI response names.
  function automatic logic [1:0] ref_merge(input logic [1:0] a, input logic [1:0] b);
    logic a_err, b_err;
    a_err = (a == SLVERR) || (a == DECERR);
    b_err = (b == SLVERR) || (b == DECERR);
    if (a_err || b_err) return (a > b) ? a : b;
    if (a == EXOKAY && b == EXOKAY) return EXOKAY;
    return OKAY;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if (cmpl_valid !== 1'b0 || cmpl_resp !== 2'd0 || cmpl_split !== 1'b0 ||
        axi_bready !== 1'b0 || req_ready !== 1'b1 || push_overflow_err !== 1'b0 ||
        outstanding_count !== 4'd0) begin
      bad++;
      $display("FAIL reset_values: got v=%b r=%0d s=%b br=%b rr=%b err=%b cnt=%0d want 0 0 0 0 1 0 0",
               cmpl_valid, cmpl_resp, cmpl_split, axi_bready, req_ready,
               push_overflow_err, outstanding_count);
    end
    $display("reset: cnt=%0d req_ready=%b", outstanding_count, req_ready);
    next_cycle();
  endtask

  task automatic test_single_unsplit();
    for (int r = 0; r < 4; r++) begin
      req_push = 1'b1; req_is_split = 1'b0; cmpl_ready = 1'b1;
      @(negedge clk);
      total++;
      if (axi_bready !== 1'b0) begin
        bad++; $display("FAIL unsplit_bready_same_cycle: got %b want 0", axi_bready);
      end
      next_cycle();
      req_push = 1'b0; axi_bvalid = 1'b1; axi_bresp = 2'(r);
      @(negedge clk);
      total++;
      if (axi_bready !== 1'b1 || cmpl_valid !== 1'b0 || outstanding_count !== 4'd1) begin
        bad++; $display("FAIL unsplit_b_phase: got br=%b v=%b cnt=%0d want 1 0 1",
                        axi_bready, cmpl_valid, outstanding_count);
      end
      next_cycle();
      axi_bvalid = 1'b0;
      @(negedge clk);
      total++;
      if (cmpl_valid !== 1'b1 || cmpl_resp !== 2'(r) || cmpl_split !== 1'b0) begin
        bad++; $display("FAIL unsplit_cmpl: got v=%b r=%0d s=%b want 1 %0d 0",
                        cmpl_valid, cmpl_resp, cmpl_split, r);
      end
      next_cycle();
      @(negedge clk);
      total++;
      if (cmpl_valid !== 1'b0 || outstanding_count !== 4'd0) begin
        bad++; $display("FAIL unsplit_after: got v=%b cnt=%0d want 0 0", cmpl_valid, outstanding_count);
      end
      $display("unsplit: bresp=%0d -> resp=%0d split=%b", r, cmpl_resp, cmpl_split);
      next_cycle();
      cmpl_ready = 1'b0;
    end
  endtask

  task automatic test_split(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] exp;
    exp = ref_merge(a, b);
    req_push = 1'b1; req_is_split = 1'b1; cmpl_ready = 1'b1;
    next_cycle();
    req_push = 1'b0; axi_bvalid = 1'b1; axi_bresp = a;
    @(negedge clk);
    total++;
    if (axi_bready !== 1'b1 || cmpl_valid !== 1'b0) begin
      bad++; $display("FAIL split_first_b: got br=%b v=%b want 1 0", axi_bready, cmpl_valid);
    end
    next_cycle();
    axi_bresp = b;
    @(negedge clk);
    total++;
    if (axi_bready !== 1'b1 || cmpl_valid !== 1'b0) begin
      bad++; $display("FAIL split_second_b: got br=%b v=%b want 1 0", axi_bready, cmpl_valid);
    end
    next_cycle();
    axi_bresp = a; cmpl_ready = 1'b0;   // B stays valid: must not be taken during completion
    @(negedge clk);
    total++;
    if (cmpl_valid !== 1'b1 || cmpl_resp !== exp || cmpl_split !== 1'b1 || axi_bready !== 1'b0) begin
      bad++; $display("FAIL split_cmpl: got v=%b r=%0d s=%b br=%b want 1 %0d 1 0",
                      cmpl_valid, cmpl_resp, cmpl_split, axi_bready, exp);
    end
    next_cycle();
    @(negedge clk);
    total++;
    if (cmpl_valid !== 1'b1 || cmpl_resp !== exp || cmpl_split !== 1'b1) begin
      bad++; $display("FAIL split_hold: got v=%b r=%0d s=%b want 1 %0d 1",
                      cmpl_valid, cmpl_resp, cmpl_split, exp);
    end
    next_cycle();
    axi_bvalid = 1'b0; cmpl_ready = 1'b1;
    next_cycle();
    @(negedge clk);
    total++;
    if (cmpl_valid !== 1'b0 || outstanding_count !== 4'd0) begin
      bad++; $display("FAIL split_after: got v=%b cnt=%0d want 0 0", cmpl_valid, outstanding_count);
    end
    $display("split: b=%0d,%0d -> resp=%0d (want %0d)", a, b, cmpl_resp, exp);
    next_cycle();
    cmpl_ready = 1'b0;
  endtask

  task automatic test_empty_b();
    axi_bvalid = 1'b1; axi_bresp = SLVERR; cmpl_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (axi_bready !== 1'b0 || cmpl_valid !== 1'b0) begin
        bad++; $display("FAIL empty_b: got br=%b v=%b want 0 0", axi_bready, cmpl_valid);
      end
      next_cycle();
    end
    req_push = 1'b1; req_is_split = 1'b0;
    @(negedge clk);
    total++;
    if (axi_bready !== 1'b0) begin
      bad++; $display("FAIL empty_push_cycle_n: got br=%b want 0", axi_bready);
    end
    next_cycle();
    req_push = 1'b0;
    @(negedge clk);
    total++;
    if (axi_bready !== 1'b1) begin
      bad++; $display("FAIL empty_push_cycle_n1: got br=%b want 1", axi_bready);
    end
    next_cycle();
    axi_bvalid = 1'b0;
    @(negedge clk);
    total++;
    if (cmpl_valid !== 1'b1 || cmpl_resp !== SLVERR || cmpl_split !== 1'b0) begin
      bad++; $display("FAIL empty_then_cmpl: got v=%b r=%0d s=%b want 1 2 0",
                      cmpl_valid, cmpl_resp, cmpl_split);
    end
    $display("empty_b: completion resp=%0d", cmpl_resp);
    next_cycle();
    cmpl_ready = 1'b0;
  endtask

  task automatic test_overflow();
    logic [7:0] pat;
    logic       mq[$];
    logic [1:0] bq[$];
    int         n_done;
    logic       s;
    logic [1:0] exp;
    pat = 8'b1011_0010;
    for (int i = 0; i < 9; i++) begin
      req_push = 1'b1; req_is_split = pat[i % 8];
      @(negedge clk);
      total++;
      if (req_ready !== (i < 8)) begin
        bad++; $display("FAIL overflow_ready_%0d: got %b want %b", i, req_ready, (i < 8));
      end
      if (i < 8) mq.push_back(pat[i]);
      next_cycle();
    end
    req_push = 1'b0;
    @(negedge clk);
    total++;
    if (outstanding_count !== 4'd8 || push_overflow_err !== 1'b1 || req_ready !== 1'b0) begin
      bad++; $display("FAIL overflow_full: got cnt=%0d err=%b rr=%b want 8 1 0",
                      outstanding_count, push_overflow_err, req_ready);
    end
    next_cycle();
    n_done = 0;
    axi_bvalid = 1'b1; cmpl_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      axi_bresp = 2'($urandom_range(0, 3));
      @(negedge clk);
      if (axi_bvalid && axi_bready) bq.push_back(axi_bresp);
      if (cmpl_valid && cmpl_ready) begin
        total++;
        if (mq.size() == 0) begin
          bad++; $display("FAIL drain_extra: unexpected completion resp=%0d", cmpl_resp);
        end else begin
          s = mq.pop_front();
          if (bq.size() != (s ? 2 : 1)) begin
            bad++; $display("FAIL drain_bcount: got %0d B responses want %0d", bq.size(), s ? 2 : 1);
            bq.delete();
          end else begin
            exp = s ? ref_merge(bq[0], bq[1]) : bq[0];
            bq.delete();
            if (cmpl_resp !== exp || cmpl_split !== s) begin
              bad++; $display("FAIL drain_%0d: got r=%0d s=%b want r=%0d s=%b",
                              n_done, cmpl_resp, cmpl_split, exp, s);
            end
          end
          $display("drain: #%0d resp=%0d split=%b", n_done, cmpl_resp, cmpl_split);
          n_done++;
        end
      end
      next_cycle();
    end
    axi_bvalid = 1'b0; cmpl_ready = 1'b0;
    @(negedge clk);
    total++;
    if (n_done != 8 || outstanding_count !== 4'd0 || push_overflow_err !== 1'b1) begin
      bad++; $display("FAIL drain_end: got done=%0d cnt=%0d err=%b want 8 0 1",
                      n_done, outstanding_count, push_overflow_err);
    end
    next_cycle();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      req_push = 1'b1; req_is_split = (i != 1);
      next_cycle();
    end
    req_push = 1'b0; axi_bvalid = 1'b1; axi_bresp = DECERR; cmpl_ready = 1'b1;
    next_cycle();
    axi_bvalid = 1'b0;
    @(negedge clk);
    total++;
    if (axi_bready !== 1'b1 || cmpl_valid !== 1'b0 || outstanding_count !== 4'd3) begin
      bad++; $display("FAIL mid_wait_second: got br=%b v=%b cnt=%0d want 1 0 3",
                      axi_bready, cmpl_valid, outstanding_count);
    end
    #1 reset = 1'b0;
    #1;
    total++;
    if (cmpl_valid !== 1'b0 || cmpl_resp !== 2'd0 || cmpl_split !== 1'b0 ||
        axi_bready !== 1'b0 || req_ready !== 1'b1 || push_overflow_err !== 1'b0 ||
        outstanding_count !== 4'd0) begin
      bad++; $display("FAIL mid_reset_async: got v=%b r=%0d s=%b br=%b rr=%b err=%b cnt=%0d",
                      cmpl_valid, cmpl_resp, cmpl_split, axi_bready, req_ready,
                      push_overflow_err, outstanding_count);
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    next_cycle();
    axi_bvalid = 1'b1; axi_bresp = OKAY;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (cmpl_valid !== 1'b0 || axi_bready !== 1'b0 || outstanding_count !== 4'd0) begin
        bad++; $display("FAIL mid_after_release: got v=%b br=%b cnt=%0d want 0 0 0",
                        cmpl_valid, axi_bready, outstanding_count);
      end
      next_cycle();
    end
    $display("reset_mid: cnt=%0d", outstanding_count);
    axi_bvalid = 1'b0; cmpl_ready = 1'b0;
  endtask

  task automatic test_random();
    logic       mq[$];
    logic [1:0] bq[$];
    int         m_count;
    logic       m_err;
    logic       hold;
    logic [1:0] hold_resp;
    logic       hold_split;
    logic       s;
    logic [1:0] exp;
    m_count = 0; m_err = 1'b0; hold = 1'b0; hold_resp = '0; hold_split = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      req_push     = ($urandom_range(0, 1) == 0);
      req_is_split = $urandom_range(0, 1) != 0;
      axi_bvalid   = ($urandom_range(0, 1) == 0);
      axi_bresp    = 2'($urandom_range(0, 3));
      cmpl_ready   = ($urandom_range(0, 2) == 0);
      @(negedge clk);
      total++;
      if (outstanding_count !== 4'(m_count) || req_ready !== (m_count != D) ||
          push_overflow_err !== m_err || (m_count == 0 && axi_bready !== 1'b0)) begin
        bad++; $display("FAIL rand_status_%0d: got cnt=%0d rr=%b err=%b br=%b want cnt=%0d err=%b",
                        c, outstanding_count, req_ready, push_overflow_err, axi_bready, m_count, m_err);
      end
      if (hold) begin
        total++;
        if (cmpl_valid !== 1'b1 || cmpl_resp !== hold_resp || cmpl_split !== hold_split) begin
          bad++; $display("FAIL rand_stable_%0d: got v=%b r=%0d s=%b want 1 %0d %b",
                          c, cmpl_valid, cmpl_resp, cmpl_split, hold_resp, hold_split);
        end
      end
      hold = cmpl_valid && !cmpl_ready;
      hold_resp = cmpl_resp; hold_split = cmpl_split;
      if (axi_bvalid && axi_bready) bq.push_back(axi_bresp);
      if (cmpl_valid && cmpl_ready) begin
        total++;
        if (mq.size() == 0) begin
          bad++; $display("FAIL rand_extra_%0d: unexpected completion", c);
        end else begin
          s = mq.pop_front();
          if (bq.size() != (s ? 2 : 1)) begin
            bad++; $display("FAIL rand_bcount_%0d: got %0d want %0d", c, bq.size(), s ? 2 : 1);
          end else begin
            exp = s ? ref_merge(bq[0], bq[1]) : bq[0];
            if (cmpl_resp !== exp || cmpl_split !== s) begin
              bad++; $display("FAIL rand_cmpl_%0d: got r=%0d s=%b want r=%0d s=%b",
                              c, cmpl_resp, cmpl_split, exp, s);
            end
          end
          bq.delete();
          m_count--;
        end
      end
      if (req_push) begin
        if (m_count + (cmpl_valid && cmpl_ready ? 1 : 0) != D) begin
          mq.push_back(req_is_split);
          m_count++;
        end else begin
          m_err = 1'b1;
        end
      end
      next_cycle();
    end
    req_push = 1'b0; axi_bvalid = 1'b0; cmpl_ready = 1'b0;
    $display("random: final cnt=%0d err=%b", outstanding_count, push_overflow_err);
  endtask

  initial begin
    reset = 1'b0; req_push = 1'b0; req_is_split = 1'b0;
    axi_bvalid = 1'b0; axi_bresp = '0; cmpl_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    next_cycle();
    test_reset();
    test_single_unsplit();
    test_split(OKAY, SLVERR);
    test_split(EXOKAY, EXOKAY);
    test_split(EXOKAY, OKAY);
    test_split(DECERR, SLVERR);
    test_empty_b();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
